serial_adder_nbit: RTL and testbench

- Parametrised multi-cycle adder. Computes a + b + cin for WIDTH-bit operands, DIGIT bits per clock, using a registered carry between steps.
- Trades area for latency against the flat ripple adders already in the codebase; the adder hardware is one DIGIT-wide ripple stage.
- Sits between producer and consumer blocks on valid/ready handshakes. The result is held until it is consumed.

---
 rtl/serial_adder_pkg.sv | 21 ++
 rtl/serial_adder_nbit_digit_adder.sv | 39 +++
 rtl/serial_adder_nbit.sv | 133 +++++++++++++
 tb/tb_serial_adder_nbit.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the serial adder: FSM state encoding and the
// helpers that derive the step count and the step-counter width.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of add cycles needed to walk WIDTH bits DIGIT bits at a time.
  function automatic int calc_steps(input int width, input int digit);
    return width / digit;
  endfunction

  // Width of the step counter; never narrower than one bit.
  function automatic int calc_count_w(input int steps);
    return (steps <= 2) ? 1 : $clog2(steps);
  endfunction

endpackage

// File: rtl/serial_adder_nbit_digit_adder.sv
// DIGIT-wide combinational ripple adder built from full_adder cells.
// This is the only adder hardware in the serial adder; it is reused every step.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module digit_adder #(
  parameter int DIGIT = 1
) (
  output logic             cout,
  output logic [DIGIT-1:0] s,
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci
);
  logic [DIGIT:0] c;

  assign c[0] = ci;
  assign cout = c[DIGIT];

  // Carry ripples from bit 0 upward through one full adder per bit.
  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    full_adder u_fa (
      .a  (x[i]),
      .b  (y[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end
endmodule

// File: rtl/serial_adder_nbit.sv
// Multi-cycle adder: computes a + b + cin over WIDTH/DIGIT steps using one
// DIGIT-wide ripple stage and a registered carry.
// Optional subtract mode is compiled in with `define SERIAL_ADDER_SUB_EN.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high in IDLE, and in DONE it follows out_ready so a
// retiring result and new operands can be exchanged on the same edge.
// out_valid is high only in DONE; sum holds until out_ready is seen.
module serial_adder_nbit
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             busy
);

  localparam int STEPS = calc_steps(WIDTH, DIGIT);
  localparam int CW    = calc_count_w(STEPS);

  // Refuse to elaborate with a width that cannot be split into whole digits.
  if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
    $error("serial_adder_nbit: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  state_t             state, state_next;
  logic [CW-1:0]      count;
  logic               carry;
  logic               carry_next;
  logic [WIDTH-1:0]   a_sh, b_sh, s_sh;
  logic [WIDTH-1:0]   s_sh_next;
  logic [DIGIT-1:0]   d;
  logic [WIDTH+DIGIT-1:0] s_cat;
  logic               last_step;
  logic               accept;
  logic [WIDTH-1:0]   b_load;
  logic               carry_load;

  // Operand conditioning at accept time; subtract is a + ~b + 1.
`ifdef SERIAL_ADDER_SUB_EN
  assign b_load     = sub ? ~b : b;
  assign carry_load = sub ? 1'b1 : cin;
`else
  assign b_load     = b;
  assign carry_load = cin;
`endif

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .cout (carry_next),
    .s    (d),
    .x    (a_sh[DIGIT-1:0]),
    .y    (b_sh[DIGIT-1:0]),
    .ci   (carry)
  );

  // New digit enters at the MSB; the oldest digit ends up at the LSB.
  assign s_cat     = {d, s_sh};
  assign s_sh_next = s_cat[WIDTH+DIGIT-1:DIGIT];
  assign last_step = (count == CW'(STEPS - 1));
  assign accept    = in_valid && in_ready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_step) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) state_next = in_valid ? RUN : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand shifters, carry and step counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      s_sh  <= '0;
      carry <= 1'b0;
      count <= '0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= b_load;
      carry <= carry_load;
      count <= '0;
    end else if (state == RUN) begin
      a_sh  <= a_sh >> DIGIT;
      b_sh  <= b_sh >> DIGIT;
      s_sh  <= s_sh_next;
      carry <= carry_next;
      count <= count + 1'b1;
    end
  end

  // Result register: written only on the final step, then held through DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         sum <= '0;
    else if (state == RUN && last_step) sum <= {carry_next, s_sh_next};
  end

endmodule

// File: tb/tb_serial_adder_nbit.sv
// Bench for serial_adder_nbit: one WIDTH=8/DIGIT=1 instance driven through
// the handshake scenarios, plus DIGIT=4 and DIGIT=8 instances sharing inputs.
module tb_serial_adder_nbit;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic       in_valid, in_ready, cin, out_valid, out_ready, busy;
  logic [7:0] a, b;
  logic [8:0] sum;
`ifdef SERIAL_ADDER_SUB_EN
  logic       sub;
`endif

  logic       x_valid, x_cin, x_out_ready;
  logic [7:0] x_a, x_b;
  logic       r4_in_ready, r4_out_valid, r4_busy;
  logic       r8_in_ready, r8_out_valid, r8_busy;
  logic [8:0] r4_sum, r8_sum;

  serial_adder_nbit #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .busy(busy)
  );

  serial_adder_nbit #(.WIDTH(8), .DIGIT(4)) u_d4 (
    .clk(clk), .rst(rst), .in_valid(x_valid), .in_ready(r4_in_ready),
    .a(x_a), .b(x_b), .cin(x_cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(1'b0),
`endif
    .out_valid(r4_out_valid), .out_ready(x_out_ready), .sum(r4_sum), .busy(r4_busy)
  );

  serial_adder_nbit #(.WIDTH(8), .DIGIT(8)) u_d8 (
    .clk(clk), .rst(rst), .in_valid(x_valid), .in_ready(r8_in_ready),
    .a(x_a), .b(x_b), .cin(x_cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(1'b0),
`endif
    .out_valid(r8_out_valid), .out_ready(x_out_ready), .sum(r8_sum), .busy(r8_busy)
  );

  // ---------------- scoreboard ----------------
  logic [8:0] exp_q[$];
  logic [8:0] exp_x[$];
  int total = 0;
  int bad   = 0;
  int acc   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_pop(input string tag, input logic [8:0] got, input bit wide);
    if (wide) begin
      if (exp_x.size() == 0) check({tag, "_q_empty"}, 32'd1, 32'd0);
      else                   check(tag, {23'd0, got}, {23'd0, exp_x.pop_front()});
    end else begin
      if (exp_q.size() == 0) check({tag, "_q_empty"}, 32'd1, 32'd0);
      else                   check(tag, {23'd0, got}, {23'd0, exp_q.pop_front()});
    end
  endtask

  function automatic logic [8:0] model(input logic [7:0] ta, input logic [7:0] tb,
                                       input logic tc, input logic ts);
    if (ts) return {1'b0, ta} + {1'b0, ~tb} + 9'd1;
    else    return {1'b0, ta} + {1'b0, tb} + {8'd0, tc};
  endfunction

  // ---------------- driver tasks (DIGIT=1 instance) ----------------
  task automatic send(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                      input logic ts, input bit keep);
    int n = 0;
    @(negedge clk);
    a = ta; b = tb; cin = tc;
`ifdef SERIAL_ADDER_SUB_EN
    sub = ts;
`endif
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("send_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    acc = cyc;
    if (keep) exp_q.push_back(model(ta, tb, tc, ts));
  endtask

  task automatic recv(input int lat, input int hold, input bit retire);
    int n = 0;
    logic [8:0] held;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("out_valid_seen", {31'd0, out_valid}, 32'd1);
    check("latency", cyc - acc, lat);
    check_pop("sum", sum, 1'b0);
    held = sum;
    repeat (hold) begin
      @(negedge clk);
      check("hold_sum", {23'd0, sum}, {23'd0, held});
      check("hold_out_valid", {31'd0, out_valid}, 32'd1);
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    if (retire) begin
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("retired_out_valid", {31'd0, out_valid}, 32'd0);
      check("retired_busy", {31'd0, busy}, 32'd0);
    end
  endtask

  // ---------------- driver task (DIGIT=4 / DIGIT=8 instances) ----------------
  task automatic run_x(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                       input bit toggle);
    int lat4 = -1;
    int lat8 = -1;
    @(negedge clk);
    x_a = ta; x_b = tb; x_cin = tc; x_valid = 1'b1;
    check("x4_in_ready", {31'd0, r4_in_ready}, 32'd1);
    check("x8_in_ready", {31'd0, r8_in_ready}, 32'd1);
    @(posedge clk);
    #1;
    x_valid = 1'b0;
    acc = cyc;
    exp_x.push_back(model(ta, tb, tc, 1'b0));
    exp_x.push_back(model(ta, tb, tc, 1'b0));
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (toggle) begin
        x_a = 8'($urandom); x_b = 8'($urandom); x_cin = 1'($urandom);
      end
      if (r4_out_valid && lat4 < 0) lat4 = cyc - acc;
      if (r8_out_valid && lat8 < 0) lat8 = cyc - acc;
    end
    check("x4_latency", lat4, 2);
    check("x8_latency", lat8, 1);
    check_pop("x4_sum", r4_sum, 1'b1);
    check_pop("x8_sum", r8_sum, 1'b1);
    check("x4_busy_done", {31'd0, r4_busy}, 32'd0);
    x_out_ready = 1'b1;
    @(posedge clk);
    #1;
    x_out_ready = 1'b0;
    check("x4_retired", {31'd0, r4_out_valid}, 32'd0);
    check("x8_retired", {31'd0, r8_out_valid}, 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b0;
`endif
    x_valid = 1'b0; x_out_ready = 1'b0; x_a = '0; x_b = '0; x_cin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_sum", {23'd0, sum}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_x4_sum", {23'd0, r4_sum}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Basic add and carry chain.
    send(8'h06, 8'h07, 1'b0, 1'b0, 1'b1);
    check("run_busy", {31'd0, busy}, 32'd1);
    check("run_in_ready", {31'd0, in_ready}, 32'd0);
    recv(8, 0, 1'b1);
    send(8'hFF, 8'h01, 1'b0, 1'b0, 1'b1);
    recv(8, 0, 1'b1);
    send(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1);
    recv(8, 0, 1'b1);

    // Back-pressure for 5 cycles, then same-edge retire and accept.
    send(8'h55, 8'h2A, 1'b1, 1'b0, 1'b1);
    recv(8, 5, 1'b0);
    @(negedge clk);
    out_ready = 1'b1;
    a = 8'h10; b = 8'h20; cin = 1'b0; in_valid = 1'b1;
    #1;
    check("same_edge_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    acc = cyc;
    exp_q.push_back(model(8'h10, 8'h20, 1'b0, 1'b0));
    check("same_edge_out_valid", {31'd0, out_valid}, 32'd0);
    check("same_edge_busy", {31'd0, busy}, 32'd1);
    recv(8, 0, 1'b1);

    // Reset in the middle of RUN discards the operation.
    send(8'h03, 8'h04, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_sum", {23'd0, sum}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_idle_valid", {31'd0, out_valid}, 32'd0);
    send(8'h01, 8'h01, 1'b0, 1'b0, 1'b1);
    recv(8, 0, 1'b1);

    // Random operands with random back-pressure.
    repeat (6) begin
      send(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0, 1'b1);
      recv(8, $urandom_range(0, 2), 1'b1);
    end

`ifdef SERIAL_ADDER_SUB_EN
    send(8'h05, 8'h07, 1'b0, 1'b1, 1'b1);
    recv(8, 0, 1'b1);
    send(8'h07, 8'h05, 1'b0, 1'b1, 1'b1);
    recv(8, 0, 1'b1);
    send(8'h07, 8'h05, 1'b1, 1'b0, 1'b1);
    recv(8, 0, 1'b1);
`endif

    // Wider digits, including the single-step case, with operand toggling.
    run_x(8'h9C, 8'h7B, 1'b1, 1'b1);
    run_x(8'hFF, 8'hFF, 1'b1, 1'b0);
    repeat (3) run_x(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
